// File: rtl/sum_accumulator.sv
// Batches COUNT unsigned samples into one ACC_W-bit total with a sticky overflow flag.
// Optional feature: define SUM_ACC_SAT_EN to clamp the total on overflow instead of wrapping.
module sum_accumulator #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = (COUNT < 1) ? 1 : $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             live_q;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;

  // live_q keeps in_ready low until the first clock edge after reset release
  assign in_ready  = live_q && !clr && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid ? ovf_q : 1'b0;

  assign sum   = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign carry = sum[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(in_data);
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = (COUNT == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef SUM_ACC_SAT_EN
            acc_d = carry ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_LAST) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator: default, narrow-overflow and COUNT=1 builds.
// Expected overflow total follows SUM_ACC_SAT_EN, matching the RTL build.
module tb_sum_accumulator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic       a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [1:0] a_in_data;
  logic [7:0] a_out_data;

  logic       b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [1:0] b_in_data;
  logic [3:0] b_out_data;

  logic       c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [1:0] c_in_data;
  logic [7:0] c_out_data;

  logic [31:0] ovf_total;

  sum_accumulator u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  sum_accumulator #(.IN_W(2), .ACC_W(4), .COUNT(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  sum_accumulator #(.IN_W(2), .ACC_W(8), .COUNT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_ovf(c_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef SUM_ACC_SAT_EN
    ovf_total = 32'd15;
`else
    ovf_total = 32'd0;
`endif
    rst_n = 1'b0;
    {a_clr, a_in_valid, a_out_ready, a_in_data} = '0;
    {b_clr, b_in_valid, b_out_ready, b_in_data} = '0;
    {c_clr, c_in_valid, c_out_ready, c_in_data} = '0;

    // reset values, then in_ready rising only at the first edge after release
    #2;
    check_output("rst_in_ready", a_in_ready, 0);
    check_output("rst_out_valid", a_out_valid, 0);
    check_output("rst_out_data", a_out_data, 0);
    check_output("rst_out_ovf", a_out_ovf, 0);
    step();
    step();
    check_output("rst_held_in_ready", a_in_ready, 0);
    #2;
    rst_n = 1'b1;
    #1;
    check_output("rel_before_edge_in_ready", a_in_ready, 0);
    step();
    check_output("rel_edge_in_ready", a_in_ready, 1);
    check_output("rel_out_valid", a_out_valid, 0);

    // samples 1,2,3,0 back-to-back
    a_in_valid = 1'b1;
    a_in_data = 2'd1; step();
    a_in_data = 2'd2; step();
    a_in_data = 2'd3; step();
    check_output("b2b_3rd_out_valid", a_out_valid, 0);
    a_in_data = 2'd0; a_out_ready = 1'b1; step();
    a_in_valid = 1'b0;
    check_output("b2b_out_valid", a_out_valid, 1);
    check_output("b2b_out_data", a_out_data, 6);
    check_output("b2b_out_ovf", a_out_ovf, 0);
    check_output("b2b_hold_in_ready", a_in_ready, 0);
    step();
    check_output("b2b_bubble_out_valid", a_out_valid, 0);
    check_output("b2b_bubble_in_ready", a_in_ready, 1);
    a_out_ready = 1'b0;

    // toggling in_valid with 3s, then back-pressure for five cycles
    a_in_data = 2'd3;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      step();
      if (i < 3) begin
        a_in_valid = 1'b0;
        step();
        check_output("tog_gap_out_valid", a_out_valid, 0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out_valid", a_out_valid, 1);
      check_output("bp_in_ready", a_in_ready, 0);
      check_output("bp_out_data", a_out_data, 12);
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    check_output("bp_consumed_out_valid", a_out_valid, 0);
    a_out_ready = 1'b0;

    // clr mid-batch blocks the accept and discards the partial total
    a_in_valid = 1'b1;
    a_in_data = 2'd1;
    step();
    step();
    a_clr = 1'b1;
    #1;
    check_output("clr_in_ready", a_in_ready, 0);
    step();
    a_clr = 1'b0;
    check_output("clr_out_valid", a_out_valid, 0);
    for (int i = 0; i < 4; i++) step();
    a_in_valid = 1'b0;
    check_output("clr_out_valid_hold", a_out_valid, 1);
    check_output("clr_out_data", a_out_data, 4);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // ACC_W=4 COUNT=8: eight 2s overflow a 4-bit accumulator
    b_in_valid = 1'b1;
    b_in_data = 2'd2;
    for (int i = 0; i < 7; i++) step();
    check_output("ovf_7th_out_valid", b_out_valid, 0);
    step();
    b_in_valid = 1'b0;
    check_output("ovf_out_valid", b_out_valid, 1);
    check_output("ovf_out_ovf", b_out_ovf, 1);
    check_output("ovf_out_data", b_out_data, ovf_total);

    // COUNT=1: a single sample goes straight to HOLD
    c_in_valid = 1'b1;
    c_in_data = 2'd3;
    check_output("c1_pre_out_valid", c_out_valid, 0);
    step();
    c_in_valid = 1'b0;
    check_output("c1_out_valid", c_out_valid, 1);
    check_output("c1_out_data", c_out_data, 3);
    check_output("c1_out_ovf", c_out_ovf, 0);

    // reset dropped between edges while holding a result
    a_in_valid = 1'b1;
    a_in_data = 2'd1;
    for (int i = 0; i < 4; i++) step();
    a_in_valid = 1'b0;
    check_output("arst_pre_out_valid", a_out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", a_out_valid, 0);
    check_output("arst_out_data", a_out_data, 0);
    check_output("arst_in_ready", a_in_ready, 0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check_output("arst_rel_in_ready", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_data = 2'd2;
    for (int i = 0; i < 4; i++) step();
    a_in_valid = 1'b0;
    check_output("arst_fresh_out_valid", a_out_valid, 1);
    check_output("arst_fresh_out_data", a_out_data, 8);
    a_out_ready = 1'b1;
    step();
    check_output("arst_fresh_consumed", a_out_valid, 0);
    a_out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
